// File: rtl/hc_logic_pkg.sv
// -----------------------------------------------------------------------------
// hc_logic_pkg
//   Shared types and constants for the 74HC-style logic blocks.
//   - hc_mode_t     : mode select encoding of the universal shift register
//   - HC_RST_ACTIVE : level at which the active-low async controls assert
// -----------------------------------------------------------------------------
package hc_logic_pkg;

  typedef enum logic [1:0] {
    HC_HOLD = 2'b00,
    HC_SHR  = 2'b01,
    HC_SHL  = 2'b10,
    HC_LOAD = 2'b11
  } hc_mode_t;

  localparam logic HC_RST_ACTIVE = 1'b0;

endpackage : hc_logic_pkg

// File: rtl/hc_dff_pc.sv
// -----------------------------------------------------------------------------
// hc_dff_pc
//   One rising-edge D flip-flop with asynchronous clear and asynchronous
//   preset, both active-low. Clear dominates preset. When the preset is not
//   wanted, the parent ties i_pre_n high and the path folds away.
// Ports
//   i_clk   in  1  clock, rising edge
//   i_clr_n in  1  async clear, active-low (dominant)
//   i_pre_n in  1  async preset, active-low; loads PRE_VAL
//   i_d     in  1  data input
//   o_q     out 1  registered output
// -----------------------------------------------------------------------------
module hc_dff_pc
  import hc_logic_pkg::*;
#(
  parameter logic PRE_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_clr_n,
  input  logic i_pre_n,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  // Storage bit: clear first, then preset, then the clocked data path.
  always_ff @(posedge i_clk or negedge i_clr_n or negedge i_pre_n) begin
    if (i_clr_n == HC_RST_ACTIVE) begin
      r_q <= 1'b0;
    end else if (i_pre_n == HC_RST_ACTIVE) begin
      r_q <= PRE_VAL;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : hc_dff_pc

// File: rtl/hc194_univ_shift.sv
// -----------------------------------------------------------------------------
// hc194_univ_shift
//   Parametrised universal shift register (74HC194 style). WIDTH D stages on
//   one clock, four modes (hold / shift right / shift left / parallel load),
//   plus a saturating shift counter that flags a fully shifted word.
//
//   Optional feature macro: HC194_SDN_EN
//     defined   -> SDN port exists; SDN low asynchronously forces
//                  Q = PRESET_VAL and SCNT = 0 (RDN low still wins).
//     undefined -> no SDN port, no set path.
//
// Parameters
//   WIDTH      number of stages (>= 2)
//   PRESET_VAL value forced by SDN (only meaningful with HC194_SDN_EN)
//   CNT_W      derived counter width, $clog2(WIDTH+1)
// Ports
//   CP     in  1      clock, rising edge
//   RDN    in  1      async master reset, active-low
//   SDN    in  1      async set, active-low (HC194_SDN_EN only)
//   S      in  2      mode: 00 hold, 01 shift right, 10 shift left, 11 load
//   DSR    in  1      serial input for shift right, enters Q[0]
//   DSL    in  1      serial input for shift left, enters Q[WIDTH-1]
//   D      in  WIDTH  parallel load data
//   Q      out WIDTH  register contents
//   QN     out WIDTH  complement of Q (combinational from Q)
//   SCNT   out CNT_W  shifts since last load/reset/set, saturating at WIDTH
//   SFULL  out 1      SCNT == WIDTH (registered)
// -----------------------------------------------------------------------------
module hc194_univ_shift
  import hc_logic_pkg::*;
#(
  parameter int                 WIDTH      = 4,
  parameter logic [WIDTH-1:0]   PRESET_VAL = {WIDTH{1'b1}},
  localparam int                CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic             CP,
  input  logic             RDN,
`ifdef HC194_SDN_EN
  input  logic             SDN,
`endif
  input  logic [1:0]       S,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic [CNT_W-1:0] SCNT,
  output logic             SFULL
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  hc_mode_t         w_mode;
  logic             w_sdn_n;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_full_next;
  logic [CNT_W-1:0] r_scnt;
  logic             r_sfull;

  assign w_mode = hc_mode_t'(S);

`ifdef HC194_SDN_EN
  assign w_sdn_n = SDN;
`else
  // Set path absent: the stage preset inputs are held inactive.
  assign w_sdn_n = 1'b1;
`endif

  // Mode mux feeding every stage's D input.
  always_comb begin
    w_q_next = w_q;
    case (w_mode)
      HC_HOLD: w_q_next = w_q;
      HC_SHR:  w_q_next = {w_q[WIDTH-2:0], DSR};
      HC_SHL:  w_q_next = {DSL, w_q[WIDTH-1:1]};
      HC_LOAD: w_q_next = D;
      default: w_q_next = w_q;
    endcase
  end

  // Register stages, each with async clear (RDN) and async preset (SDN).
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      hc_dff_pc #(
        .PRE_VAL (PRESET_VAL[gi])
      ) u_dff (
        .i_clk   (CP),
        .i_clr_n (RDN),
        .i_pre_n (w_sdn_n),
        .i_d     (w_q_next[gi]),
        .o_q     (w_q[gi])
      );
    end
  endgenerate

  // Next shift count: direction-agnostic, saturates at WIDTH, load clears.
  always_comb begin
    w_cnt_next = r_scnt;
    case (w_mode)
      HC_HOLD: w_cnt_next = r_scnt;
      HC_SHR,
      HC_SHL: begin
        if (r_scnt == CNT_MAX) begin
          w_cnt_next = r_scnt;
        end else begin
          w_cnt_next = r_scnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      HC_LOAD: w_cnt_next = {CNT_W{1'b0}};
      default: w_cnt_next = r_scnt;
    endcase
    w_full_next = (w_cnt_next == CNT_MAX);
  end

  // Shift counter and full flag; cleared asynchronously by reset or set.
`ifdef HC194_SDN_EN
  always_ff @(posedge CP or negedge RDN or negedge w_sdn_n) begin
`else
  always_ff @(posedge CP or negedge RDN) begin
`endif
    if (RDN == HC_RST_ACTIVE) begin
      r_scnt  <= {CNT_W{1'b0}};
      r_sfull <= 1'b0;
    end else if (w_sdn_n == HC_RST_ACTIVE) begin
      r_scnt  <= {CNT_W{1'b0}};
      r_sfull <= 1'b0;
    end else begin
      r_scnt  <= w_cnt_next;
      r_sfull <= w_full_next;
    end
  end

  assign Q     = w_q;
  assign QN    = ~w_q;
  assign SCNT  = r_scnt;
  assign SFULL = r_sfull;

endmodule : hc194_univ_shift

// File: tb/tb_hc194_univ_shift.sv
// -----------------------------------------------------------------------------
// tb_hc194_univ_shift
//   Directed, self-checking bench for hc194_univ_shift at WIDTH=4,
//   PRESET_VAL=4'hF. Inputs change #1 after a rising CP edge; outputs are
//   sampled #1 after the edge or #1 after an async control change.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hc194_univ_shift;

  logic       CP;
  logic       RDN;
  logic       SDN;
  logic [1:0] S;
  logic       DSR;
  logic       DSL;
  logic [3:0] D;
  logic [3:0] Q;
  logic [3:0] QN;
  logic [2:0] SCNT;
  logic       SFULL;

  int total;
  int bad;

  hc194_univ_shift #(
    .WIDTH      (4),
    .PRESET_VAL (4'hF)
  ) dut (
    .CP    (CP),
    .RDN   (RDN),
`ifdef HC194_SDN_EN
    .SDN   (SDN),
`endif
    .S     (S),
    .DSR   (DSR),
    .DSL   (DSL),
    .D     (D),
    .Q     (Q),
    .QN    (QN),
    .SCNT  (SCNT),
    .SFULL (SFULL)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  // One rising edge, then settle before sampling.
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic load(input logic [3:0] val);
    S = 2'b11; D = val;
    tick();
    S = 2'b00;
  endtask

  task automatic test_reset();
    RDN = 1'b0; SDN = 1'b1; S = 2'b11; D = 4'hF; DSR = 1'b1; DSL = 1'b1;
    tick();
    // Load request while reset is held must be ignored.
    total++; if (Q !== 4'h0) begin bad++; $display("FAIL rst_hold_q got=%h exp=%h", Q, 4'h0); end
    total++; if (SCNT !== 3'd0) begin bad++; $display("FAIL rst_hold_scnt got=%0d exp=0", SCNT); end
    RDN = 1'b1;
    load(4'hA);
    S = 2'b01; DSR = 1'b0;
    tick();
    S = 2'b00;
    total++; if (Q !== 4'h4) begin bad++; $display("FAIL pre_rst_q got=%h exp=%h", Q, 4'h4); end
    load(4'hA);
    total++; if (Q !== 4'hA) begin bad++; $display("FAIL pre_rst_load got=%h exp=%h", Q, 4'hA); end
    // Async reset mid-cycle: effect must appear before the next edge.
    RDN = 1'b0;
    #1;
    total++; if (Q !== 4'h0) begin bad++; $display("FAIL rst_async_q got=%h exp=%h", Q, 4'h0); end
    total++; if (QN !== 4'hF) begin bad++; $display("FAIL rst_async_qn got=%h exp=%h", QN, 4'hF); end
    total++; if (SCNT !== 3'd0) begin bad++; $display("FAIL rst_async_scnt got=%0d exp=0", SCNT); end
    total++; if (SFULL !== 1'b0) begin bad++; $display("FAIL rst_async_sfull got=%b exp=0", SFULL); end
    #1;
    RDN = 1'b1;
    tick();
    total++; if (Q !== 4'h0) begin bad++; $display("FAIL rst_release_q got=%h exp=%h", Q, 4'h0); end
  endtask

  task automatic test_load_hold();
    load(4'h5);
    total++; if (Q !== 4'h5) begin bad++; $display("FAIL load_q got=%h exp=%h", Q, 4'h5); end
    total++; if (QN !== 4'hA) begin bad++; $display("FAIL load_qn got=%h exp=%h", QN, 4'hA); end
    total++; if (SCNT !== 3'd0) begin bad++; $display("FAIL load_scnt got=%0d exp=0", SCNT); end
    S = 2'b00; D = 4'h3; DSR = 1'b1; DSL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (Q !== 4'h5) begin bad++; $display("FAIL hold_q[%0d] got=%h exp=%h", i, Q, 4'h5); end
    end
  endtask

  task automatic test_shift_right();
    logic [3:0] dsr_seq;
    logic [3:0] exp_q [4];
    dsr_seq = 4'b1101;  // applied LSB first: 1,0,1,1
    exp_q[0] = 4'h1; exp_q[1] = 4'h2; exp_q[2] = 4'h5; exp_q[3] = 4'hB;
    load(4'h0);
    S = 2'b01;
    for (int i = 0; i < 4; i++) begin
      DSR = dsr_seq[i];
      tick();
      total++; if (Q !== exp_q[i]) begin bad++; $display("FAIL shr_q[%0d] got=%h exp=%h", i, Q, exp_q[i]); end
      total++; if (SCNT !== 3'(i + 1)) begin bad++; $display("FAIL shr_scnt[%0d] got=%0d exp=%0d", i, SCNT, i + 1); end
    end
    total++; if (SFULL !== 1'b1) begin bad++; $display("FAIL shr_sfull got=%b exp=1", SFULL); end
    DSR = 1'b0;
    tick();
    total++; if (Q !== 4'h6) begin bad++; $display("FAIL shr_sat_q got=%h exp=%h", Q, 4'h6); end
    total++; if (SCNT !== 3'd4) begin bad++; $display("FAIL shr_sat_scnt got=%0d exp=4", SCNT); end
    total++; if (SFULL !== 1'b1) begin bad++; $display("FAIL shr_sat_sfull got=%b exp=1", SFULL); end
    S = 2'b00;
  endtask

  task automatic test_shift_left();
    logic [3:0] exp_q [3];
    exp_q[0] = 4'h4; exp_q[1] = 4'h2; exp_q[2] = 4'h1;
    load(4'h8);
    S = 2'b10; DSL = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (Q !== exp_q[i]) begin bad++; $display("FAIL shl_q[%0d] got=%h exp=%h", i, Q, exp_q[i]); end
    end
    total++; if (SCNT !== 3'd3) begin bad++; $display("FAIL shl_scnt got=%0d exp=3", SCNT); end
    total++; if (SFULL !== 1'b0) begin bad++; $display("FAIL shl_sfull3 got=%b exp=0", SFULL); end
    DSL = 1'b1;
    tick();
    total++; if (Q !== 4'h8) begin bad++; $display("FAIL shl_q4 got=%h exp=%h", Q, 4'h8); end
    total++; if (SFULL !== 1'b1) begin bad++; $display("FAIL shl_sfull4 got=%b exp=1", SFULL); end
    S = 2'b00;
  endtask

  task automatic test_mixed();
    load(4'h6);
    total++; if (SCNT !== 3'd0) begin bad++; $display("FAIL mix_load_scnt got=%0d exp=0", SCNT); end
    total++; if (SFULL !== 1'b0) begin bad++; $display("FAIL mix_load_sfull got=%b exp=0", SFULL); end
    S = 2'b01; DSR = 1'b0;
    tick();
    total++; if (Q !== 4'hC) begin bad++; $display("FAIL mix_shr_q got=%h exp=%h", Q, 4'hC); end
    S = 2'b10; DSL = 1'b1;
    tick();
    total++; if (Q !== 4'hE) begin bad++; $display("FAIL mix_shl_q got=%h exp=%h", Q, 4'hE); end
    total++; if (SCNT !== 3'd2) begin bad++; $display("FAIL mix_scnt got=%0d exp=2", SCNT); end
    S = 2'b00;
    tick();
    total++; if (SCNT !== 3'd2) begin bad++; $display("FAIL mix_hold_scnt got=%0d exp=2", SCNT); end
    total++; if (Q !== 4'hE) begin bad++; $display("FAIL mix_hold_q got=%h exp=%h", Q, 4'hE); end
  endtask

  task automatic test_back_to_back();
    // Saturate, then load straight after: count and flag clear in one edge.
    S = 2'b01; DSR = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++; if (SFULL !== 1'b1) begin bad++; $display("FAIL b2b_full got=%b exp=1", SFULL); end
    total++; if (Q !== 4'hF) begin bad++; $display("FAIL b2b_q got=%h exp=%h", Q, 4'hF); end
    S = 2'b11; D = 4'h9;
    tick();
    total++; if (Q !== 4'h9) begin bad++; $display("FAIL b2b_load_q got=%h exp=%h", Q, 4'h9); end
    total++; if (SCNT !== 3'd0) begin bad++; $display("FAIL b2b_load_scnt got=%0d exp=0", SCNT); end
    total++; if (SFULL !== 1'b0) begin bad++; $display("FAIL b2b_load_sfull got=%b exp=0", SFULL); end
    S = 2'b10; DSL = 1'b0;
    tick();
    total++; if (Q !== 4'h4) begin bad++; $display("FAIL b2b_shl_q got=%h exp=%h", Q, 4'h4); end
    total++; if (SCNT !== 3'd1) begin bad++; $display("FAIL b2b_shl_scnt got=%0d exp=1", SCNT); end
    S = 2'b00;
  endtask

`ifdef HC194_SDN_EN
  task automatic test_sdn();
    load(4'h3);
    S = 2'b01; DSR = 1'b0;
    tick();
    S = 2'b00;
    SDN = 1'b0;
    #1;
    total++; if (Q !== 4'hF) begin bad++; $display("FAIL sdn_q got=%h exp=%h", Q, 4'hF); end
    total++; if (SCNT !== 3'd0) begin bad++; $display("FAIL sdn_scnt got=%0d exp=0", SCNT); end
    RDN = 1'b0;
    #1;
    total++; if (Q !== 4'h0) begin bad++; $display("FAIL sdn_rdn_q got=%h exp=%h", Q, 4'h0); end
    RDN = 1'b1;
    tick();
    total++; if (Q !== 4'hF) begin bad++; $display("FAIL sdn_reassert_q got=%h exp=%h", Q, 4'hF); end
    S = 2'b00;
    SDN = 1'b1;
    #1;
    total++; if (Q !== 4'hF) begin bad++; $display("FAIL sdn_release_q got=%h exp=%h", Q, 4'hF); end
    tick();
    total++; if (Q !== 4'hF) begin bad++; $display("FAIL sdn_hold_q got=%h exp=%h", Q, 4'hF); end
    total++; if (SCNT !== 3'd0) begin bad++; $display("FAIL sdn_hold_scnt got=%0d exp=0", SCNT); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_hold();
    test_shift_right();
    test_shift_left();
    test_mixed();
    test_back_to_back();
`ifdef HC194_SDN_EN
    test_sdn();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hc194_univ_shift
